// File: rtl/dac_xy_sequencer_pkg.sv
// Shared constants for the X/Y DAC sequencer: word width, channel codes
// and the one-hot state encoding.
package dac_xy_sequencer_pkg;

    localparam int BITS_DEF = 12;

    localparam logic AXIS_X = 1'b0;
    localparam logic AXIS_Y = 1'b1;

    typedef logic [6:0] state_t;

    localparam state_t ST_IDLE   = 7'b000_0001;
    localparam state_t ST_LOAD_X = 7'b000_0010;
    localparam state_t ST_WAIT_X = 7'b000_0100;
    localparam state_t ST_LOAD_Y = 7'b000_1000;
    localparam state_t ST_WAIT_Y = 7'b001_0000;
    localparam state_t ST_LDAC   = 7'b010_0000;
    localparam state_t ST_SETTLE = 7'b100_0000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dac_xy_sequencer_if.sv
// Stepper/DAC-driver side signals of the sequencer. master = stepper and
// driver environment, slave = the sequencer itself.
interface dac_xy_sequencer_if import dac_xy_sequencer_pkg::*; #(
    parameter int BITS = BITS_DEF
);
    logic [BITS-1:0] i_x;
    logic [BITS-1:0] i_y;
    logic            i_force;
    logic            i_dac_ready;
    logic            o_dac_strobe;
    logic            o_dac_axis;
    logic [BITS-1:0] o_dac_value;
    logic            o_ldac_n;
    logic            o_halt;
    logic            o_busy;

    modport master (
        output i_x, i_y, i_force, i_dac_ready,
        input  o_dac_strobe, o_dac_axis, o_dac_value, o_ldac_n, o_halt, o_busy
    );

    modport slave (
        input  i_x, i_y, i_force, i_dac_ready,
        output o_dac_strobe, o_dac_axis, o_dac_value, o_ldac_n, o_halt, o_busy
    );
endinterface

// File: rtl/dac_xy_sequencer_dwell_timer.sv
// Saturating down-counter shared by the LDAC pulse and the settle dwell;
// done is the terminal-count compare against zero.
module dac_dwell_timer #(
    parameter int W = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_count,
    output logic         o_done
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_count && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == '0);
endmodule

// File: rtl/dac_xy_sequencer.sv
// Writes changed stepper coordinates to the dual-channel DAC driver, pulses
// LDAC once per point, dwells, and halts the stepper until the point is out.
module dac_xy_sequencer import dac_xy_sequencer_pkg::*; #(
    parameter int BITS          = BITS_DEF,
    parameter int LDAC_CYCLES   = 2,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    dac_xy_sequencer_if.slave    bus
);
    localparam int CNT_MAX = max_int(LDAC_CYCLES, SETTLE_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] LDAC_LOAD   = CNT_W'(LDAC_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    state_t          r_state;
    logic [BITS-1:0] r_x_sh;
    logic [BITS-1:0] r_y_sh;
    logic [BITS-1:0] r_value;
    logic            r_valid;
    logic            r_force_pend;
    logic            r_owe_y;
    logic            r_first;
    logic            r_strobe;
    logic            r_axis;
    logic            r_ldac_n;

    logic             w_in_idle;
    logic             w_dx_chg;
    logic             w_dy_chg;
    logic             w_rdy_ok;
    logic             w_tmr_load;
    logic             w_tmr_count;
    logic             w_tmr_done;
    logic [CNT_W-1:0] w_tmr_val;

    assign w_in_idle = (r_state == ST_IDLE);
    assign w_dx_chg  = !r_valid || r_force_pend || (bus.i_x != r_x_sh);
    assign w_dy_chg  = !r_valid || r_force_pend || (bus.i_y != r_y_sh);
    // The driver keeps ready high for one clock after a strobe, so the first
    // WAIT cycle must not treat it as completion.
    assign w_rdy_ok  = !r_first && bus.i_dac_ready;

    assign bus.o_halt       = !w_in_idle || w_dx_chg || w_dy_chg;
    assign bus.o_busy       = !w_in_idle;
    assign bus.o_dac_strobe = r_strobe;
    assign bus.o_dac_axis   = r_axis;
    assign bus.o_dac_value  = r_value;
    assign bus.o_ldac_n     = r_ldac_n;

    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = LDAC_LOAD;
        if (((r_state == ST_WAIT_Y) || ((r_state == ST_WAIT_X) && !r_owe_y)) && w_rdy_ok) begin
            w_tmr_load = 1'b1;
        end else if ((r_state == ST_LDAC) && w_tmr_done) begin
            w_tmr_load = 1'b1;
            w_tmr_val  = SETTLE_LOAD;
        end
    end

    assign w_tmr_count = (r_state == ST_LDAC) || (r_state == ST_SETTLE);

    dac_dwell_timer #(.W(CNT_W)) u_dwell (
        .i_clk      (i_clk),
        .i_rst      (i_reset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_count    (w_tmr_count),
        .o_done     (w_tmr_done)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_x_sh       <= '0;
            r_y_sh       <= '0;
            r_value      <= '0;
            r_valid      <= 1'b0;
            r_force_pend <= 1'b0;
            r_owe_y      <= 1'b0;
            r_first      <= 1'b0;
            r_strobe     <= 1'b0;
            r_axis       <= AXIS_X;
            r_ldac_n     <= 1'b1;
        end else begin
            r_strobe <= 1'b0;
            // A force arriving on the very cycle IDLE is left must survive.
            if (bus.i_force) begin
                r_force_pend <= 1'b1;
            end else if (w_in_idle && (w_dx_chg || w_dy_chg)) begin
                r_force_pend <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_dx_chg || w_dy_chg) begin
                        r_x_sh  <= bus.i_x;
                        r_y_sh  <= bus.i_y;
                        r_owe_y <= w_dy_chg;
                        r_state <= w_dx_chg ? ST_LOAD_X : ST_LOAD_Y;
                    end
                end
                ST_LOAD_X: begin
                    if (bus.i_dac_ready) begin
                        r_strobe <= 1'b1;
                        r_axis   <= AXIS_X;
                        r_value  <= r_x_sh;
                        r_first  <= 1'b1;
                        r_state  <= ST_WAIT_X;
                    end
                end
                ST_WAIT_X: begin
                    r_first <= 1'b0;
                    if (w_rdy_ok) begin
                        if (r_owe_y) begin
                            r_state <= ST_LOAD_Y;
                        end else begin
                            r_ldac_n <= 1'b0;
                            r_state  <= ST_LDAC;
                        end
                    end
                end
                ST_LOAD_Y: begin
                    if (bus.i_dac_ready) begin
                        r_strobe <= 1'b1;
                        r_axis   <= AXIS_Y;
                        r_value  <= r_y_sh;
                        r_first  <= 1'b1;
                        r_state  <= ST_WAIT_Y;
                    end
                end
                ST_WAIT_Y: begin
                    r_first <= 1'b0;
                    if (w_rdy_ok) begin
                        r_ldac_n <= 1'b0;
                        r_state  <= ST_LDAC;
                    end
                end
                ST_LDAC: begin
                    if (w_tmr_done) begin
                        r_ldac_n <= 1'b1;
                        if (SETTLE_CYCLES == 0) begin
                            r_valid <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_SETTLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (w_tmr_done) begin
                        r_valid <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule
